// File: rtl/window_line_buffer.sv
// ---------------------------------------------------------------------------
// window_line_buffer
//
// Streaming KxK sliding-window generator. Pixels arrive in raster order, one
// per in_valid cycle. K-1 previous image rows are held in per-row line
// memories indexed by column. On each accepted pixel the memories shift down
// by one row at that column, and the window shifts left by one column. A
// complete window is presented one cycle after every pixel whose window lies
// entirely inside the image.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     pixel accepted on this cycle
//   in_data      pixel value
//   img_width    frame width, sampled on the first pixel of a frame
//   img_height   frame height, sampled on the first pixel of a frame
//   out_valid    one-cycle pulse: out_window holds a complete window
//   out_window   element (i,j) at [(i*K+j)*DATA_WIDTH +: DATA_WIDTH],
//                i = row (0 = top/oldest), j = col (0 = left/oldest)
//   frame_done   one-cycle pulse after the last pixel of a frame
//   out_row/out_col  (only with WINDOW_LINE_BUFFER_COORD_EN defined)
//                image coordinates of the window's bottom-right pixel
//
// Optional feature macro: WINDOW_LINE_BUFFER_COORD_EN
// ---------------------------------------------------------------------------
module window_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WIDTH  = 28,
  parameter int K          = 3,
  parameter int CNT_W      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [CNT_W-1:0]            img_width,
  input  logic [CNT_W-1:0]            img_height,
  output logic                        out_valid,
  output logic [K*K*DATA_WIDTH-1:0]   out_window,
  output logic                        frame_done
`ifdef WINDOW_LINE_BUFFER_COORD_EN
  ,
  output logic [CNT_W-1:0]            out_row,
  output logic [CNT_W-1:0]            out_col
`endif
);

  localparam int AddrW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CNT_W-1:0] KMin  = CNT_W'(K);
  localparam logic [CNT_W-1:0] KLast = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] MaxW  = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] One   = CNT_W'(1);

  logic [CNT_W-1:0]      rowCnt_q, rowCnt_d;
  logic [CNT_W-1:0]      colCnt_q, colCnt_d;
  logic [CNT_W-1:0]      widthCfg_q, widthCfg_d;
  logic [CNT_W-1:0]      heightCfg_q, heightCfg_d;
  logic [DATA_WIDTH-1:0] win_q [K][K];
  logic [DATA_WIDTH-1:0] win_d [K][K];
  logic                  outValid_q, outValid_d;
  logic                  frameDone_q, frameDone_d;

  logic [DATA_WIDTH-1:0] lineMem [K-1][MAX_WIDTH];
  logic [DATA_WIDTH-1:0] memRd   [K-1];
  logic [AddrW-1:0]      memAddr;

  logic [CNT_W-1:0]      clampWidth, clampHeight;
  logic [CNT_W-1:0]      curWidth, curHeight;
  logic                  frameStart, lastCol, lastRow;

  assign memAddr    = colCnt_q[AddrW-1:0];
  assign frameStart = (rowCnt_q == '0) && (colCnt_q == '0);

  // The first pixel of a frame must already use the new geometry, so the
  // clamped live inputs bypass the latched config while row=col=0.
  always_comb begin
    clampWidth  = img_width;
    clampHeight = img_height;
    if (img_width < KMin) begin
      clampWidth = KMin;
    end else if (img_width > MaxW) begin
      clampWidth = MaxW;
    end
    if (img_height < KMin) begin
      clampHeight = KMin;
    end
    curWidth  = frameStart ? clampWidth  : widthCfg_q;
    curHeight = frameStart ? clampHeight : heightCfg_q;
    lastCol   = (colCnt_q == curWidth - One);
    lastRow   = (rowCnt_q == curHeight - One);
  end

  // Line memory read port: one word per stored row at the current column.
  always_comb begin
    for (int k = 0; k < K-1; k++) begin
      memRd[k] = lineMem[k][memAddr];
    end
  end

  // Next-state logic for counters, config latch and the window registers.
  always_comb begin
    rowCnt_d    = rowCnt_q;
    colCnt_d    = colCnt_q;
    widthCfg_d  = widthCfg_q;
    heightCfg_d = heightCfg_q;
    win_d       = win_q;
    outValid_d  = 1'b0;
    frameDone_d = 1'b0;
    if (in_valid) begin
      if (frameStart) begin
        widthCfg_d  = clampWidth;
        heightCfg_d = clampHeight;
      end
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K-1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      for (int i = 0; i < K-1; i++) begin
        win_d[i][K-1] = memRd[i];
      end
      win_d[K-1][K-1] = in_data;
      outValid_d = (rowCnt_q >= KLast) && (colCnt_q >= KLast);
      if (lastCol) begin
        colCnt_d = '0;
        if (lastRow) begin
          rowCnt_d    = '0;
          frameDone_d = 1'b1;
        end else begin
          rowCnt_d = rowCnt_q + One;
        end
      end else begin
        colCnt_d = colCnt_q + One;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rowCnt_q    <= '0;
      colCnt_q    <= '0;
      widthCfg_q  <= KMin;
      heightCfg_q <= KMin;
      outValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      rowCnt_q    <= rowCnt_d;
      colCnt_q    <= colCnt_d;
      widthCfg_q  <= widthCfg_d;
      heightCfg_q <= heightCfg_d;
      outValid_q  <= outValid_d;
      frameDone_q <= frameDone_d;
      win_q       <= win_d;
    end
  end

  // Line memories are never cleared: rows that still hold stale data are
  // only ever read while out_valid is being suppressed. The reads above see
  // the old contents, giving read-before-write behaviour at one address.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int k = 0; k < K-2; k++) begin
        lineMem[k][memAddr] <= lineMem[k+1][memAddr];
      end
      lineMem[K-2][memAddr] <= in_data;
    end
  end

  always_comb begin
    out_window = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        out_window[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] = win_q[i][j];
      end
    end
  end

  assign out_valid  = outValid_q;
  assign frame_done = frameDone_q;

`ifdef WINDOW_LINE_BUFFER_COORD_EN
  logic [CNT_W-1:0] outRow_q, outCol_q;

  // Coordinates follow the window registers, so they are captured on every
  // accept and are meaningful only alongside out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      outRow_q <= '0;
      outCol_q <= '0;
    end else if (in_valid) begin
      outRow_q <= rowCnt_q;
      outCol_q <= colCnt_q;
    end
  end

  assign out_row = outRow_q;
  assign out_col = outCol_q;
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_window_line_buffer
//
// Directed bench for window_line_buffer with K=3, MAX_WIDTH=28. Each scenario
// task drives frames through playFrame, which only records what the DUT
// emitted, and then compares the recorded windows against a ramp-image model.
// ---------------------------------------------------------------------------
module tb_window_line_buffer;

  localparam int DW   = 32;
  localparam int MAXW = 28;
  localparam int K    = 3;
  localparam int CW   = 5;
  localparam int WINW = K*K*DW;

  logic            clk = 1'b0;
  logic            reset;
  logic            inValid;
  logic [DW-1:0]   inData;
  logic [CW-1:0]   imgWidth;
  logic [CW-1:0]   imgHeight;
  logic            outValid;
  logic [WINW-1:0] outWindow;
  logic            frameDone;
`ifdef WINDOW_LINE_BUFFER_COORD_EN
  logic [CW-1:0]   outRow;
  logic [CW-1:0]   outCol;
`endif

  int errors = 0;
  int checks = 0;

  logic [WINW-1:0] obsWin[$];
  int              obsIdx[$];
  int              fdIdx[$];
  int              obsRow[$];
  int              obsCol[$];
  int              idleHits;

  window_line_buffer #(
    .DATA_WIDTH(DW),
    .MAX_WIDTH (MAXW),
    .K         (K),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inValid),
    .in_data   (inData),
    .img_width (imgWidth),
    .img_height(imgHeight),
    .out_valid (outValid),
    .out_window(outWindow),
    .frame_done(frameDone)
`ifdef WINDOW_LINE_BUFFER_COORD_EN
    ,
    .out_row   (outRow),
    .out_col   (outCol)
`endif
  );

  always #5 clk = ~clk;

  // Ramp image: pixel (r,c) = base + r*w + c.
  function automatic logic [WINW-1:0] expWindow(int w, int base, int r, int c);
    logic [WINW-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        v[(i*K+j)*DW +: DW] = DW'(base + (r-K+1+i)*w + (c-K+1+j));
      end
    end
    return v;
  endfunction

  function automatic logic [WINW-1:0] packWin(int vals[K*K]);
    logic [WINW-1:0] v;
    v = '0;
    for (int n = 0; n < K*K; n++) begin
      v[n*DW +: DW] = DW'(vals[n]);
    end
    return v;
  endfunction

  task automatic applyReset();
    reset   = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one frame (or its first numPix pixels) and records every window,
  // frame_done pulse and any out_valid seen on an idle cycle.
  task automatic playFrame(int w, int h, int base, int numPix, int maxGap);
    int gap;
    obsWin.delete();
    obsIdx.delete();
    fdIdx.delete();
    obsRow.delete();
    obsCol.delete();
    idleHits  = 0;
    imgWidth  = CW'(w);
    imgHeight = CW'(h);
    for (int p = 0; p < numPix; p++) begin
      if (p > 0 && maxGap > 0 && $urandom_range(0, 1) == 1) begin
        gap = $urandom_range(1, maxGap);
        repeat (gap) begin
          inValid = 1'b0;
          @(posedge clk);
          #1;
          if (outValid) idleHits++;
        end
      end
      inValid = 1'b1;
      inData  = DW'(base + p);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      if (p == 0) begin
        imgWidth  = CW'(w + 3);
        imgHeight = CW'(h + 2);
      end
      if (outValid) begin
        obsWin.push_back(outWindow);
        obsIdx.push_back(p);
`ifdef WINDOW_LINE_BUFFER_COORD_EN
        obsRow.push_back(int'(outRow));
        obsCol.push_back(int'(outCol));
`endif
      end
      if (frameDone) fdIdx.push_back(p);
    end
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %0b expected 0", outValid);
    end
    checks++;
    if (outWindow !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out_window: got %h expected 0", outWindow);
    end
    checks++;
    if (frameDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_frame_done: got %0b expected 0", frameDone);
    end
  endtask

  task automatic test_basic();
    int first[K*K] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    int last[K*K]  = '{8, 9, 10, 13, 14, 15, 18, 19, 20};
    int r, c;
    playFrame(5, 4, 1, 20, 0);
    checks++;
    if (obsIdx.size() !== 6) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d expected 6", obsIdx.size());
    end
    for (int n = 0; n < obsIdx.size() && n < 6; n++) begin
      r = 2 + n / 3;
      c = 2 + n % 3;
      checks++;
      if (obsIdx[n] !== r*5 + c) begin
        errors++;
        $display("[TB] FAIL basic_pos%0d: got pixel %0d expected %0d", n, obsIdx[n], r*5 + c);
      end
      checks++;
      if (obsWin[n] !== expWindow(5, 1, r, c)) begin
        errors++;
        $display("[TB] FAIL basic_win%0d: got %h expected %h", n, obsWin[n], expWindow(5, 1, r, c));
      end
    end
    if (obsWin.size() == 6) begin
      checks++;
      if (obsWin[0] !== packWin(first)) begin
        errors++;
        $display("[TB] FAIL basic_first: got %h expected %h", obsWin[0], packWin(first));
      end
      checks++;
      if (obsWin[5] !== packWin(last)) begin
        errors++;
        $display("[TB] FAIL basic_last: got %h expected %h", obsWin[5], packWin(last));
      end
    end
    checks++;
    if (!(fdIdx.size() == 1 && fdIdx[0] == 19)) begin
      errors++;
      $display("[TB] FAIL basic_frame_done: got %0d pulses expected 1 after pixel 20", fdIdx.size());
    end
  endtask

  task automatic test_idle_gaps();
    int r, c;
    playFrame(5, 4, 1, 20, 3);
    checks++;
    if (idleHits !== 0) begin
      errors++;
      $display("[TB] FAIL gaps_idle_valid: got %0d expected 0", idleHits);
    end
    checks++;
    if (obsIdx.size() !== 6) begin
      errors++;
      $display("[TB] FAIL gaps_count: got %0d expected 6", obsIdx.size());
    end
    for (int n = 0; n < obsIdx.size() && n < 6; n++) begin
      r = 2 + n / 3;
      c = 2 + n % 3;
      checks++;
      if (obsWin[n] !== expWindow(5, 1, r, c)) begin
        errors++;
        $display("[TB] FAIL gaps_win%0d: got %h expected %h", n, obsWin[n], expWindow(5, 1, r, c));
      end
    end
    checks++;
    if (fdIdx.size() !== 1) begin
      errors++;
      $display("[TB] FAIL gaps_frame_done: got %0d expected 1", fdIdx.size());
    end
  endtask

  task automatic test_max_frame();
    int r, c, bad;
    bad = 0;
    playFrame(28, 28, 1, 28*28, 0);
    checks++;
    if (obsIdx.size() !== 676) begin
      errors++;
      $display("[TB] FAIL max_count: got %0d expected 676", obsIdx.size());
    end
    for (int n = 0; n < obsIdx.size() && n < 676; n++) begin
      r = 2 + n / 26;
      c = 2 + n % 26;
      if (obsIdx[n] !== r*28 + c || obsWin[n] !== expWindow(28, 1, r, c)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL max_windows: got %0d wrong windows expected 0", bad);
    end
    if (obsWin.size() > 0) begin
      checks++;
      if (obsWin[obsWin.size()-1][DW-1:0] !== DW'(726)) begin
        errors++;
        $display("[TB] FAIL max_last_topleft: got %0d expected 726", obsWin[obsWin.size()-1][DW-1:0]);
      end
    end
    checks++;
    if (!(fdIdx.size() == 1 && fdIdx[0] == 783)) begin
      errors++;
      $display("[TB] FAIL max_frame_done: got %0d pulses expected 1", fdIdx.size());
    end
  endtask

  task automatic test_clamp();
    // Width 2 / height 1 are below K and must act as a 3x3 frame.
    playFrame(2, 1, 500, 9, 0);
    checks++;
    if (!(obsIdx.size() == 1 && obsIdx[0] == 8)) begin
      errors++;
      $display("[TB] FAIL clamp_count: got %0d windows expected 1 at pixel 9", obsIdx.size());
    end
    if (obsWin.size() == 1) begin
      checks++;
      if (obsWin[0] !== expWindow(3, 500, 2, 2)) begin
        errors++;
        $display("[TB] FAIL clamp_win: got %h expected %h", obsWin[0], expWindow(3, 500, 2, 2));
      end
    end
    checks++;
    if (!(fdIdx.size() == 1 && fdIdx[0] == 8)) begin
      errors++;
      $display("[TB] FAIL clamp_frame_done: got %0d pulses expected 1", fdIdx.size());
    end
  endtask

  task automatic test_back_to_back();
    playFrame(5, 4, 1, 20, 0);
    checks++;
    if (obsIdx.size() !== 6) begin
      errors++;
      $display("[TB] FAIL b2b_a_count: got %0d expected 6", obsIdx.size());
    end
    playFrame(4, 3, 1000, 12, 0);
    checks++;
    if (obsIdx.size() !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_b_count: got %0d expected 2", obsIdx.size());
    end
    for (int n = 0; n < obsIdx.size() && n < 2; n++) begin
      checks++;
      if (obsIdx[n] !== 10 + n || obsWin[n] !== expWindow(4, 1000, 2, 2 + n)) begin
        errors++;
        $display("[TB] FAIL b2b_b_win%0d: got pixel %0d %h expected pixel %0d %h",
                 n, obsIdx[n], obsWin[n], 10 + n, expWindow(4, 1000, 2, 2 + n));
      end
    end
    checks++;
    if (!(fdIdx.size() == 1 && fdIdx[0] == 11)) begin
      errors++;
      $display("[TB] FAIL b2b_b_frame_done: got %0d pulses expected 1", fdIdx.size());
    end
  endtask

  task automatic test_reset_midframe();
    int r, c;
    playFrame(5, 4, 1, 12, 0);
    checks++;
    if (obsIdx.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midrst_pre_count: got %0d expected 0", obsIdx.size());
    end
    applyReset();
    checks++;
    if (outValid !== 1'b0 || outWindow !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_cleared: got valid %0b window %h expected 0", outValid, outWindow);
    end
    playFrame(5, 4, 1, 20, 0);
    checks++;
    if (!(obsIdx.size() == 6 && obsIdx[0] == 12)) begin
      errors++;
      $display("[TB] FAIL midrst_count: got %0d windows expected 6 from pixel 13", obsIdx.size());
    end
    for (int n = 0; n < obsIdx.size() && n < 6; n++) begin
      r = 2 + n / 3;
      c = 2 + n % 3;
      checks++;
      if (obsWin[n] !== expWindow(5, 1, r, c)) begin
        errors++;
        $display("[TB] FAIL midrst_win%0d: got %h expected %h", n, obsWin[n], expWindow(5, 1, r, c));
      end
    end
  endtask

`ifdef WINDOW_LINE_BUFFER_COORD_EN
  task automatic test_coord();
    playFrame(5, 4, 1, 20, 0);
    checks++;
    if (obsRow.size() !== 6) begin
      errors++;
      $display("[TB] FAIL coord_count: got %0d expected 6", obsRow.size());
    end
    for (int n = 0; n < obsRow.size() && n < 6; n++) begin
      checks++;
      if (obsRow[n] !== 2 + n / 3 || obsCol[n] !== 2 + n % 3) begin
        errors++;
        $display("[TB] FAIL coord%0d: got (%0d,%0d) expected (%0d,%0d)",
                 n, obsRow[n], obsCol[n], 2 + n / 3, 2 + n % 3);
      end
    end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    inValid   = 1'b0;
    inData    = '0;
    imgWidth  = CW'(5);
    imgHeight = CW'(4);
    test_reset();
    test_basic();
    test_idle_gaps();
    test_max_frame();
    test_clamp();
    test_back_to_back();
    test_reset_midframe();
`ifdef WINDOW_LINE_BUFFER_COORD_EN
    test_coord();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
Streaming KxK sliding-window generator for the conv/pool datapath. It accepts one raster-order pixel per valid cycle and stores K-1 previous image rows in per-row circular memories. It emits the full KxK window once the window lies entirely inside the image. Image width and height are runtime-programmable up to MAX_WIDTH, so one instance serves every feature-map size.

Parameters:
DATA_WIDTH, 32, bits per pixel
MAX_WIDTH, 28, maximum image width; depth of each line memory
K, 3, window size (KxK); legal range 2..5
CNT_W, 5, width of the row/column counters and config ports; must satisfy 2^CNT_W > MAX_WIDTH

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  pixel accepted on this cycle
in_data  in  DATA_WIDTH  pixel value
img_width  in  CNT_W  frame width in pixels, sampled at frame start
img_height  in  CNT_W  frame height in rows, sampled at frame start
out_valid  out  1  out_window holds a complete window
out_window  out  K*K*DATA_WIDTH  window; element (i,j) at bits [(i*K+j)*DATA_WIDTH +: DATA_WIDTH], i=row (0=top/oldest), j=col (0=left/oldest)
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (sync, high):
  - row/col counters = 0, window registers = 0, out_valid = 0, out_window = 0, frame_done = 0.
  - Latched width/height are reloaded at the next frame start.
  - Line memory contents are not cleared; stale data is never exposed because of valid gating.
- Config latch:
  - Occurs on the first accepted pixel of a frame (row=0, col=0).
  - Width is clamped to [K, MAX_WIDTH]; height is clamped to [K, 2^CNT_W-1].
  - Mid-frame changes on img_width/img_height are ignored.
- Accept (in_valid=1) at (row r, col c):
  - For each k in 0..K-2, read line_mem[k][c] (the pixel from row r-K+1+k, column c).
  - Shift the memories: line_mem[k][c] <= line_mem[k+1][c], and line_mem[K-2][c] <= in_data.
  - The window shifts left one column; the new right column = {read values top-down, in_data at bottom}.
  - col increments; at col = width-1, col wraps to 0 and row increments.
  - At row = height-1 and col = width-1, both counters wrap to 0 and frame_done pulses the next cycle.
- Output:
  - out_valid = 1 on the cycle after an accept with r >= K-1 and c >= K-1.
  - That window covers rows r-K+1..r and cols c-K+1..c.
  - Otherwise out_valid = 0; it is a one-cycle pulse per qualifying pixel.
  - Fixed latency: 1 cycle.
  - Windows never straddle a row boundary: columns c < K-1 produce no output.
- in_valid=0: counters, window and memories hold; out_valid = 0 next cycle; out_window holds its last value.
- No backpressure: the downstream consumer must accept every out_valid pulse.
- Windows per frame = (height-K+1)*(width-K+1).
- Back-to-back frames: the first pixel of the next frame may follow the last pixel of the previous one with no gap cycle; new config takes effect on it.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame; no window from the aborted frame is emitted after reset.
- Line memory: one read and one write per row per accept, same address. Register array or simple dual-port RAM with read-before-write semantics.

Optional Feature:
Macro WINDOW_LINE_BUFFER_COORD_EN.
- Defined: adds outputs out_row and out_col (CNT_W each), registered with out_window.
  - They give the image coordinates of the window's bottom-right pixel.
  - Reset value 0; valid only when out_valid = 1.
- Undefined: these ports do not exist and there is no extra logic.

Test Plan:
1. K=3, width=5, height=4, pixels 1..20 with continuous valid.
   - First out_valid follows pixel 13, with window {1,2,3; 6,7,8; 11,12,13}.
   - Exactly 6 windows are emitted; the last is {8,9,10; 13,14,15; 18,19,20}.
   - frame_done pulses once, after pixel 20.
2. Same frame with in_valid randomly deasserted for 1-3 cycles between pixels.
   - Identical window sequence and count to scenario 1; out_valid is never high on a cycle following an idle cycle.
3. Width=28 (MAX), height=28, ramp data.
   - 676 windows emitted.
   - Window at (27,27) has top-left element = 25*28+25+1 = 726.
4. Frame A width=5 followed back-to-back by frame B width=4, height=3.
   - B yields exactly 2 windows, with correct data and no frame-A pixels in them.
   - img_width changed mid-frame B has no effect.
5. Assert reset after pixel 12 of scenario 1, then restart the frame.
   - No out_valid until pixel 13 of the new frame; window contents as in scenario 1.
6. With WINDOW_LINE_BUFFER_COORD_EN defined, scenario 1.
   - out_row/out_col sequence: (2,2),(2,3),(2,4),(3,2),(3,3),(3,4).
